// File: rtl/cxd2545_subq_shifter.sv
// -----------------------------------------------------------------------------
// cxd2545_subq_shifter
//
// Serial SUBQ output stage of the CXD2545 emulator. The soft CPU delivers one
// 80-bit Q-channel frame per subcode block. The frame is buffered in a hold
// register and then moved into a shift register. At that point SCOR is raised
// and the frame is clocked out on SQSO, LSB first, one bit per SQCK rising
// edge coming from the mechacon.
//
// Ports
//   sys_clk      in   1   system clock, all logic on its rising edge
//   reset_n      in   1   asynchronous active-low reset
//   frame_valid  in   1   producer offers a frame on frame_data
//   frame_ready  out  1   hold register empty (registered)
//   frame_data   in  80   Q frame, byte 0 (CTRL/ADR) in bits [7:0]
//   sqck         in   1   SQCK, already synchronised to sys_clk
//   scor         out  1   subcode-sync flag
//   sqso         out  1   serial Q data
//   busy         out  1   a frame is armed or being shifted
//   drop_cnt     out  8   frames replaced before being read (saturating)
//   abort_cnt    out  8   reads abandoned on SQCK timeout (saturating)
// -----------------------------------------------------------------------------
module cxd2545_subq_shifter #(
    parameter int SCOR_CYCLES  = 6800,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [79:0] frame_data,
    input  logic        sqck,
    output logic        scor,
    output logic        sqso,
    output logic        busy,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  abort_cnt
);

    localparam int SCW = $clog2(SCOR_CYCLES + 1);
    localparam int IDW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [SCW-1:0] SCOR_LOAD  = SCW'(SCOR_CYCLES);
    localparam logic [SCW-1:0] SCOR_ONE   = SCW'(1);
    localparam logic [IDW-1:0] IDLE_LIMIT = IDW'(IDLE_TIMEOUT);
    localparam logic [6:0]     LAST_BIT   = 7'd79;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [79:0]     r_hold;
    logic [79:0]     r_shift;
    logic            r_hold_full;
    logic            r_frame_ready;
    logic            r_sqck_d;
    logic            r_scor;
    logic            r_sqso;
    logic            r_busy;
    logic [6:0]      r_bitcnt;
    logic [SCW-1:0]  r_scor_cnt;
    logic [IDW-1:0]  r_idle_cnt;
    logic [7:0]      r_drop_cnt;
    logic [7:0]      r_abort_cnt;

    logic            w_accept;
    logic            w_rise;
    logic            w_transfer;
    logic            w_shift_rise;
    logic            w_last_bit;
    logic            w_timeout;
    logic [IDW-1:0]  w_idle_inc;

    // frame_ready comes straight from a register, so there is no
    // combinational path from frame_valid back to the producer.
    assign w_accept   = frame_valid & r_frame_ready;
    assign w_rise     = sqck & ~r_sqck_d;
    assign w_idle_inc = r_idle_cnt + 1'b1;

    assign frame_ready = r_frame_ready;
    assign scor        = r_scor;
    assign sqso        = r_sqso;
    assign busy        = r_busy;
    assign drop_cnt    = r_drop_cnt;
    assign abort_cnt   = r_abort_cnt;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: transfer > rise > timeout. A rise that coincides with a
    // transfer is dropped, and a rise in the timeout cycle keeps the read alive.
    always_comb begin
        w_state_nxt  = r_state;
        w_transfer   = 1'b0;
        w_shift_rise = 1'b0;
        w_last_bit   = 1'b0;
        w_timeout    = 1'b0;
        if (r_hold_full && (r_state != S_SHIFT)) begin
            w_transfer  = 1'b1;
            w_state_nxt = S_ARMED;
        end else if (w_rise && ((r_state == S_ARMED) || (r_state == S_SHIFT))) begin
            w_shift_rise = 1'b1;
            w_last_bit   = (r_bitcnt == LAST_BIT);
            w_state_nxt  = w_last_bit ? S_DONE : S_SHIFT;
        end else if ((r_state == S_SHIFT) && (w_idle_inc == IDLE_LIMIT)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full   <= 1'b0;
            r_frame_ready <= 1'b1;
            r_sqck_d      <= 1'b0;
            r_scor        <= 1'b0;
            r_scor_cnt    <= '0;
            r_sqso        <= 1'b0;
            r_busy        <= 1'b0;
            r_bitcnt      <= '0;
            r_idle_cnt    <= '0;
            r_drop_cnt    <= '0;
            r_abort_cnt   <= '0;
        end else begin
            r_sqck_d <= sqck;
            r_busy   <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_SHIFT);

            // Accept and transfer are mutually exclusive: accept needs the
            // hold register empty, transfer needs it full.
            if (w_accept) begin
                r_hold_full   <= 1'b1;
                r_frame_ready <= 1'b0;
            end else if (w_transfer) begin
                r_hold_full   <= 1'b0;
                r_frame_ready <= 1'b1;
            end

            // SCOR is only ever high while ARMED, so any accepted rise ends it.
            if (w_transfer) begin
                r_scor     <= 1'b1;
                r_scor_cnt <= SCOR_LOAD;
            end else if (w_shift_rise) begin
                r_scor     <= 1'b0;
                r_scor_cnt <= '0;
            end else if (r_scor) begin
                if (r_scor_cnt > SCOR_ONE) begin
                    r_scor_cnt <= r_scor_cnt - 1'b1;
                end else begin
                    r_scor     <= 1'b0;
                    r_scor_cnt <= '0;
                end
            end

            if (w_transfer) begin
                r_sqso     <= r_hold[0];
                r_bitcnt   <= '0;
                r_idle_cnt <= '0;
            end else if (w_shift_rise) begin
                r_sqso     <= w_last_bit ? 1'b0 : r_shift[1];
                r_bitcnt   <= r_bitcnt + 1'b1;
                r_idle_cnt <= '0;
            end else if (w_timeout) begin
                r_sqso     <= 1'b0;
                r_idle_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_idle_cnt <= w_idle_inc;
            end

            // Replacing an armed frame means the mechacon never read it.
            if (w_transfer && (r_state == S_ARMED) && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            if (w_timeout && (r_abort_cnt != 8'hFF)) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end
        end
    end

    // Frame payload registers carry no reset; hold_full and the state
    // machine qualify their contents.
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_hold <= frame_data;
        end
        if (w_transfer) begin
            r_shift <= r_hold;
        end else if (w_shift_rise) begin
            r_shift <= {1'b0, r_shift[79:1]};
        end
    end

endmodule

// File: tb/tb_cxd2545_subq_shifter.sv
// -----------------------------------------------------------------------------
// tb_cxd2545_subq_shifter
//
// Scoreboard bench for cxd2545_subq_shifter. The stimulus pushes the sqso
// value expected after each SCOR rise and after each SQCK rise it issues. A
// negedge monitor pops and compares those values. Status outputs are checked
// directly by the stimulus at fixed cycle offsets.
// -----------------------------------------------------------------------------
module tb_cxd2545_subq_shifter;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        frame_valid;
    logic        frame_ready;
    logic [79:0] frame_data;
    logic        sqck;
    logic        scor;
    logic        sqso;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [7:0]  abort_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic exp_q[$];

    localparam logic [79:0] F_BASIC = 80'h0123456789ABCDEF0155;
    localparam logic [79:0] F_A     = 80'hA5A55A5AC3C33C3CF00F;
    localparam logic [79:0] F_B     = 80'h13579BDF2468ACE08001;
    localparam logic [79:0] F_E     = 80'hDEADBEEFCAFEF00D1234;
    localparam logic [79:0] F_C     = 80'h80000000000000000001;
    localparam logic [79:0] F_D     = 80'h7FFFFFFFFFFFFFFFFFFE;
    localparam logic [79:0] F_F     = 80'h0F0F0F0F0F0F0F0F0F0F;
    localparam logic [79:0] F_G     = 80'h3333CCCC3333CCCC3333;
    localparam logic [79:0] F_H     = 80'h5555AAAA5555AAAA5555;

    cxd2545_subq_shifter #(
        .SCOR_CYCLES (8),
        .IDLE_TIMEOUT(100)
    ) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .sqck       (sqck),
        .scor       (scor),
        .sqso       (sqso),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .abort_cnt  (abort_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: an output event is a SCOR rise or the cycle after the DUT
    // saw an SQCK rise (sqck goes high just after a posedge, so the rise is
    // seen here one negedge early and compared one negedge later).
    logic mon_sq_prev   = 1'b0;
    logic mon_ev        = 1'b0;
    logic mon_scor_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (mon_ev || (scor && !mon_scor_prev)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sqso_event: sqso=%b with no expected value queued (t=%0t)", sqso, $time);
            end else begin
                chk("sqso_bit", {31'd0, sqso}, {31'd0, exp_q.pop_front()});
            end
        end
        mon_ev        = sqck && !mon_sq_prev;
        mon_sq_prev   = sqck;
        mon_scor_prev = scor;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a posedge.
    task automatic load(input logic [79:0] d, output logic scor_acc);
        int n;
        n = 0;
        scor_acc    = 1'b0;
        frame_data  = d;
        frame_valid = 1'b1;
        while (!frame_ready && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!frame_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: frame_ready=%b after %0d cycles, want 1", frame_ready, n);
            frame_valid = 1'b0;
        end else begin
            @(posedge sys_clk); #1;
            frame_valid = 1'b0;
            scor_acc    = scor;
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic pulse(input logic e);
        exp_q.push_back(e);
        sqck = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sqck = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic read_bits(input logic [79:0] d, input int from, input int to);
        logic b;
        for (int k = from; k <= to; k++) begin
            b = (k < 80) ? d[k % 80] : 1'b0;
            pulse(b);
        end
    endtask

    initial begin
        logic sa;
        int   nscor;

        reset_n     = 1'b0;
        frame_valid = 1'b0;
        frame_data  = '0;
        sqck        = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_frame_ready", {31'd0, frame_ready}, 32'd1);
        chk("rst_scor",        {31'd0, scor},        32'd0);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_drop",        {24'd0, drop_cnt},    32'd0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(posedge sys_clk); #1;

        // 1: basic read
        exp_q.push_back(F_BASIC[0]);
        load(F_BASIC, sa);
        chk("t1_scor_at_accept", {31'd0, sa},   32'd0);
        chk("t1_scor_after_xfer", {31'd0, scor}, 32'd1);
        chk("t1_busy_armed",     {31'd0, busy}, 32'd1);
        exp_q.push_back(F_BASIC[1]);
        sqck = 1'b1;
        @(posedge sys_clk); #1;
        chk("t1_scor_first_rise", {31'd0, scor}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sqck = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        read_bits(F_BASIC, 2, 80);
        chk("t1_done_busy",  {31'd0, busy},   32'd0);
        chk("t1_done_sqso",  {31'd0, sqso},   32'd0);
        chk("t1_done_abort", {24'd0, abort_cnt}, 32'd0);

        // 2: SCOR expiry with no sqck
        exp_q.push_back(F_A[0]);
        load(F_A, sa);
        nscor = 0;
        for (int i = 0; i < 20; i++) begin
            if (scor) nscor++;
            @(posedge sys_clk); #1;
        end
        chk("t2_scor_width", nscor, 32'd8);
        repeat (200) @(posedge sys_clk);
        #1;
        chk("t2_busy_held", {31'd0, busy},      32'd1);
        chk("t2_no_abort",  {24'd0, abort_cnt}, 32'd0);
        chk("t2_no_drop",   {24'd0, drop_cnt},  32'd0);

        // 3: unread replacement of A by B
        exp_q.push_back(F_B[0]);
        load(F_B, sa);
        nscor = 0;
        for (int i = 0; i < 20; i++) begin
            if (scor) nscor++;
            @(posedge sys_clk); #1;
        end
        chk("t3_scor_reload", nscor, 32'd8);
        chk("t3_drop",        {24'd0, drop_cnt}, 32'd1);
        read_bits(F_B, 1, 80);
        chk("t3_done_busy",   {31'd0, busy}, 32'd0);

        // 4: back-pressure while shifting E
        exp_q.push_back(F_E[0]);
        load(F_E, sa);
        read_bits(F_E, 1, 40);
        load(F_C, sa);
        chk("t4_c_held_ready", {31'd0, frame_ready}, 32'd0);
        frame_data  = F_D;
        frame_valid = 1'b1;
        read_bits(F_E, 41, 79);
        chk("t4_d_stalled", {31'd0, frame_ready}, 32'd0);
        chk("t4_busy_shift", {31'd0, busy},       32'd1);
        exp_q.push_back(1'b0);
        exp_q.push_back(F_C[0]);
        sqck = 1'b1;
        @(posedge sys_clk); #1;
        chk("t4_done_busy",  {31'd0, busy},        32'd0);
        chk("t4_done_ready", {31'd0, frame_ready}, 32'd0);
        @(posedge sys_clk); #1;
        chk("t4_c_xfer_busy",  {31'd0, busy},        32'd1);
        chk("t4_c_xfer_scor",  {31'd0, scor},        32'd1);
        chk("t4_c_xfer_ready", {31'd0, frame_ready}, 32'd1);
        @(posedge sys_clk); #1;
        chk("t4_d_accepted", {31'd0, frame_ready}, 32'd0);
        frame_valid = 1'b0;
        sqck        = 1'b0;
        @(posedge sys_clk); #1;
        chk("t4_d_xfer_sqso",  {31'd0, sqso},        {31'd0, F_D[0]});
        chk("t4_d_xfer_drop",  {24'd0, drop_cnt},    32'd2);
        chk("t4_d_xfer_ready", {31'd0, frame_ready}, 32'd1);
        repeat (2) @(posedge sys_clk);
        #1;

        // 5: timeout after 30 rises of D
        read_bits(F_D, 1, 29);
        exp_q.push_back(F_D[30]);
        sqck = 1'b1;
        @(posedge sys_clk); #1;
        repeat (2) @(posedge sys_clk);
        #1 sqck = 1'b0;
        repeat (97) @(posedge sys_clk);
        #1;
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        @(posedge sys_clk); #1;
        chk("t5_busy_after",  {31'd0, busy},      32'd0);
        chk("t5_sqso_after",  {31'd0, sqso},      32'd0);
        chk("t5_abort",       {24'd0, abort_cnt}, 32'd1);
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        chk("t5_idle_busy",  {31'd0, busy},      32'd0);
        chk("t5_idle_abort", {24'd0, abort_cnt}, 32'd1);
        chk("t5_idle_drop",  {24'd0, drop_cnt},  32'd2);

        // 6: asynchronous reset at bit 50 with the hold register full
        exp_q.push_back(F_F[0]);
        load(F_F, sa);
        read_bits(F_F, 1, 50);
        load(F_G, sa);
        chk("t6_g_held", {31'd0, frame_ready}, 32'd0);
        @(posedge sys_clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_rst_scor",  {31'd0, scor},        32'd0);
        chk("t6_rst_sqso",  {31'd0, sqso},        32'd0);
        chk("t6_rst_busy",  {31'd0, busy},        32'd0);
        chk("t6_rst_ready", {31'd0, frame_ready}, 32'd1);
        chk("t6_rst_drop",  {24'd0, drop_cnt},    32'd0);
        chk("t6_rst_abort", {24'd0, abort_cnt},   32'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("t6_post_ready", {31'd0, frame_ready}, 32'd1);
        chk("t6_post_busy",  {31'd0, busy},        32'd0);
        exp_q.push_back(F_H[0]);
        load(F_H, sa);
        read_bits(F_H, 1, 80);
        chk("t6_h_done_busy", {31'd0, busy},     32'd0);
        chk("t6_h_drop",      {24'd0, drop_cnt}, 32'd0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
